decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised, pipelined RV32I decode stage sitting between the fetch stage and the register-read/execute stage of the pipelined core. It accepts one instruction word plus PC per cycle over a valid/ready handshake. It classifies the instruction into its encoding format and extracts register indices, the sign-extended immediate, the ALU operation and an illegal-instruction flag. Results are registered with one cycle of latency, with optional skid buffering for full throughput under backpressure, and a flush input for branch redirect.

## Interface
- Parameters:
  - WORD_SIZE, 32, instruction word width; only 32 is legal.
  - XLEN, 32, width of PC and immediate outputs; must be ≥ 32.
  - SKID, 1, 1 = two-entry output (output register + skid register, registered in_ready); 0 = single output register, combinational in_ready.
- Ports:
  - CLK  in  1  clock; all state updates on the rising edge.
  - rst  in  1  reset, synchronous, active-high.
  - flush  in  1  drop all held and incoming instructions this cycle.
  - in_valid  in  1  fetch presents an instruction.
  - in_ready  out  1  stage accepts this cycle.
  - in_inst  in  WORD_SIZE  instruction word.
  - in_pc  in  XLEN  instruction address.
  - out_valid  out  1  decoded bundle valid.
  - out_ready  in  1  downstream accepts this cycle.
  - out_pc  out  XLEN  registered PC.
  - out_fmt  out  6  one-hot format {J,U,B,S,I,R}; 0 when illegal.
  - out_rd, out_rs1, out_rs2  out  5 each  register indices; forced to 0 where the format has no such field.
  - out_funct3  out  3  inst[14:12].
  - out_imm  out  XLEN  sign-extended immediate; 0 for R.
  - out_alu_op  out  4  ALU operation code.
  - out_illegal  out  1  unsupported encoding.

## Operation
- Opcode map:
  - R: OP (0110011).
  - I: OP_IMM (0010011), LOAD (0000011), JALR (1100111), MISC_MEM (0001111), SYSTEM (1110011).
  - S: STORE (0100011).
  - B: BRANCH (1100011).
  - U: LUI (0110111), AUIPC (0010111).
  - J: JAL (1101111).
- Illegal: inst[1:0] ≠ 2'b11, or an opcode outside the map. Illegal words still flow through with out_illegal=1, out_fmt=0 and all other fields 0 except out_pc.
- Immediates follow the standard RV32I bit scatter per format, sign-extended from inst[31] to XLEN. U format is inst[31:12]<<12, then sign-extended.
- alu_op encoding is {alt, funct3}:
  - OP: alt = inst[30].
  - OP_IMM: alt = inst[30] only when funct3 = 101, otherwise 0.
  - BRANCH: 4'b1000 (SUB, compare).
  - LOAD, STORE, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM: 4'b0000 (ADD).
- Field zeroing:
  - rd = 0 for S and B.
  - rs2 = 0 for I, U and J.
  - rs1 = 0 for U and J.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Every accepted instruction appears exactly once, in order.
- SKID=0: in_ready = !out_valid || out_ready.
- SKID=1:
  - in_ready = !skid_valid (registered).
  - If an accept occurs while the output register is held, the decoded bundle goes to the skid register.
  - When the output drains, the skid entry moves to the output register first.
- Flush has priority over everything: out_valid and skid_valid are cleared next cycle, and any input presented in the flush cycle is discarded (in_ready still reads as computed, but no data is captured).

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on out_* after edge N.
- Throughput is 1 instruction per cycle while out_ready=1, for both SKID values.
- Reset values: out_valid=0, skid_valid=0, all out_* data = 0, in_ready=1.
- rst asserted mid-stream discards held entries exactly like flush. rst overrides flush.
- Output data is stable while out_valid && !out_ready.
- SKID=1 with a full skid: in_ready=0 the next cycle and stays 0 until the output register drains.
- Simultaneous in and out transfer with SKID=1 and an empty skid: the new bundle loads the output register directly and the skid stays empty.

## Structure
- Shared package rv_pkg holds:
  - opcode localparams;
  - format one-hot bit positions;
  - alu_op codes (ALU_ADD=4'b0000, ALU_SUB=4'b1000, ...);
  - a packed struct decode_bundle_t {pc, fmt, rd, rs1, rs2, funct3, imm, alu_op, illegal}.
- One combinational sub-module rv_inst_decode (inst, pc → decode_bundle_t). decode_stage adds only registers, the skid and handshake logic.

## Test plan
- addi x1,x2,-5 = 0xFFB10093, pc 0x100 → next cycle out_valid=1, fmt=I, rd=1, rs1=2, rs2=0, imm=0xFFFFFFFB, alu_op=0000, pc=0x100.
- sub x3,x1,x2 = 0x402081B3 → fmt=R, rd=3, rs1=1, rs2=2, imm=0, alu_op=1000.
- sw x5,8(x6) = 0x00532423 → fmt=S, rd=0, rs1=6, rs2=5, imm=8. Follow with 0x00000000 → illegal=1, fmt=0.
- Stream of 8 instructions with out_ready held low for 3 cycles mid-stream (SKID=1, then SKID=0) → no loss or duplication, order preserved, in_ready deasserts after the skid fills, full rate resumes on release.
- flush asserted with output and skid both full and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed instructions never appear.
- rst asserted mid-stream, then flush and rst together → all outputs 0, out_valid=0 on the cycle after the edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, format bit positions, ALU codes and
// the decoded bundle that travels from decode to register-read.
package rv_pkg;

    // Bundle fields are sized for the widest supported XLEN; narrower cores truncate.
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    localparam int FMT_W = 6;
    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [FMT_W-1:0]    fmt;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [XLEN_MAX-1:0] imm;
        logic [3:0]          alu_op;
        logic                illegal;
    } decode_bundle_t;

    function automatic logic [FMT_W-1:0] fmt_onehot(input int pos);
        return FMT_W'(1) << pos;
    endfunction

endpackage

// File: rtl/rv_inst_decode.sv
// Purely combinational RV32I field extraction: instruction word + PC in,
// decode_bundle_t out. Unknown opcodes produce an all-zero bundle flagged illegal.
module rv_inst_decode
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output decode_bundle_t  bundle_o
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [FMT_W-1:0] fmt;
    logic [3:0]       alu_op;
    logic [31:0]      imm32;
    logic             has_rd;
    logic             has_rs1;
    logic             has_rs2;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        fmt    = '0;
        alu_op = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                fmt    = fmt_onehot(FMT_R);
                alu_op = {inst_i[30], funct3};
            end
            OPC_OP_IMM: begin
                fmt    = fmt_onehot(FMT_I);
                alu_op = {(funct3 == 3'b101) && inst_i[30], funct3};
            end
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: fmt = fmt_onehot(FMT_I);
            OPC_STORE:          fmt = fmt_onehot(FMT_S);
            OPC_BRANCH: begin
                fmt    = fmt_onehot(FMT_B);
                alu_op = ALU_SUB;
            end
            OPC_LUI, OPC_AUIPC: fmt = fmt_onehot(FMT_U);
            OPC_JAL:            fmt = fmt_onehot(FMT_J);
            default:            ;
        endcase
    end

    always_comb begin
        imm32 = '0;
        if (fmt[FMT_I]) begin
            imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        end else if (fmt[FMT_S]) begin
            imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        end else if (fmt[FMT_B]) begin
            imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        end else if (fmt[FMT_U]) begin
            imm32 = {inst_i[31:12], 12'h000};
        end else if (fmt[FMT_J]) begin
            imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        end
    end

    assign has_rd  = fmt[FMT_R] | fmt[FMT_I] | fmt[FMT_U] | fmt[FMT_J];
    assign has_rs1 = fmt[FMT_R] | fmt[FMT_I] | fmt[FMT_S] | fmt[FMT_B];
    assign has_rs2 = fmt[FMT_R] | fmt[FMT_S] | fmt[FMT_B];

    always_comb begin
        bundle_o         = '0;
        bundle_o.pc      = XLEN_MAX'(pc_i);
        bundle_o.fmt     = fmt;
        bundle_o.illegal = (fmt == '0);
        bundle_o.alu_op  = alu_op;
        bundle_o.imm     = XLEN_MAX'($signed(imm32));
        bundle_o.rd      = has_rd  ? inst_i[11:7]  : 5'd0;
        bundle_o.rs1     = has_rs1 ? inst_i[19:15] : 5'd0;
        bundle_o.rs2     = has_rs2 ? inst_i[24:20] : 5'd0;
        if (fmt != '0) begin
            bundle_o.funct3 = funct3;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: one-cycle registered decode with valid/ready handshake,
// optional skid register for full throughput under backpressure, and flush.
module decode_stage
    import rv_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int XLEN      = 32,
    parameter int SKID      = 1
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_inst,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [5:0]           out_fmt,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [2:0]           out_funct3,
    output logic [XLEN-1:0]      out_imm,
    output logic [3:0]           out_alu_op,
    output logic                 out_illegal
);

    decode_bundle_t dec_bundle;
    decode_bundle_t out_q;
    decode_bundle_t out_d;
    logic           out_valid_q;
    logic           out_valid_d;
    logic           out_free;
    logic           accept;

    rv_inst_decode #(.XLEN(XLEN)) u_decode (
        .inst_i   (in_inst),
        .pc_i     (in_pc),
        .bundle_o (dec_bundle)
    );

    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    generate
        if (SKID != 0) begin : g_skid
            decode_bundle_t skid_q;
            decode_bundle_t skid_d;
            logic           skid_valid_q;
            logic           skid_valid_d;

            // Registered ready: only a full skid can refuse, so fetch never sees out_ready.
            assign in_ready = !skid_valid_q;

            always_comb begin
                out_d        = out_q;
                out_valid_d  = out_valid_q;
                skid_d       = skid_q;
                skid_valid_d = skid_valid_q;
                if (flush) begin
                    out_valid_d  = 1'b0;
                    skid_valid_d = 1'b0;
                end else if (out_free) begin
                    if (skid_valid_q) begin
                        out_d        = skid_q;
                        out_valid_d  = 1'b1;
                        skid_valid_d = 1'b0;
                    end else begin
                        out_valid_d = accept;
                        if (accept) out_d = dec_bundle;
                    end
                end else if (accept) begin
                    skid_d       = dec_bundle;
                    skid_valid_d = 1'b1;
                end
            end

            // NOTE: skid payload has no reset; it is never observed unless skid_valid_q is set.
            always_ff @(posedge CLK) begin
                skid_q <= skid_d;
            end

            always_ff @(posedge CLK) begin
                if (rst) skid_valid_q <= 1'b0;
                else     skid_valid_q <= skid_valid_d;
            end
        end else begin : g_direct
            assign in_ready = out_free;

            always_comb begin
                out_d       = out_q;
                out_valid_d = out_valid_q;
                if (flush) begin
                    out_valid_d = 1'b0;
                end else if (out_free) begin
                    out_valid_d = accept;
                    if (accept) out_d = dec_bundle;
                end
            end
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = XLEN'(out_q.pc);
    assign out_fmt     = out_q.fmt;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_funct3  = out_q.funct3;
    assign out_imm     = XLEN'(out_q.imm);
    assign out_alu_op  = out_q.alu_op;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: one channel with SKID=1 and one with SKID=0,
// each with its own driver, expected-queue and monitor, sharing a reference decoder.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        illegal;
    } exp_t;

    logic CLK = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [5:0] fmt, input int rd,
                                input int rs1, input int rs2, input int f3,
                                input logic [31:0] imm, input logic [3:0] alu, input logic ill);
        exp_t e;
        e.pc = pc; e.fmt = fmt; e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2);
        e.funct3 = 3'(f3); e.imm = imm; e.alu_op = alu; e.illegal = ill;
        return e;
    endfunction

    // Reference decoder: classify by opcode letter, then build fields with plain arithmetic.
    function automatic exp_t ref_model(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e;
        byte         kind;
        int unsigned u;
        int          s;
        int          imm;
        int unsigned f3;
        int unsigned alt;
        u = w;
        s = w;
        e = '0;
        e.pc = pc;
        case (w[6:0])
            7'h33:                             kind = "R";
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: kind = "I";
            7'h23:                             kind = "S";
            7'h63:                             kind = "B";
            7'h37, 7'h17:                      kind = "U";
            7'h6F:                             kind = "J";
            default:                           kind = "X";
        endcase
        if (kind == "X") begin
            e.illegal = 1'b1;
            return e;
        end
        f3  = (u >> 12) & 7;
        alt = (u >> 30) & 1;
        e.funct3 = 3'(f3);
        imm = 0;
        case (kind)
            "I": imm = s >>> 20;
            "S": imm = (s >>> 25) * 32 + int'((u >> 7) & 31);
            "B": imm = (w[31] ? -4096 : 0) + int'(((u >> 7) & 1) * 2048)
                       + int'(((u >> 25) & 63) * 32) + int'(((u >> 8) & 15) * 2);
            "U": imm = int'(u & 32'hFFFF_F000);
            "J": imm = (w[31] ? -1048576 : 0) + int'(((u >> 12) & 255) * 4096)
                       + int'(((u >> 20) & 1) * 2048) + int'(((u >> 21) & 1023) * 2);
            default: imm = 0;
        endcase
        e.imm = 32'(imm);
        case (kind)
            "R": e.fmt = 6'd1;
            "I": e.fmt = 6'd2;
            "S": e.fmt = 6'd4;
            "B": e.fmt = 6'd8;
            "U": e.fmt = 6'd16;
            default: e.fmt = 6'd32;
        endcase
        if (kind == "R" || kind == "I" || kind == "U" || kind == "J") e.rd  = 5'((u >> 7) & 31);
        if (kind == "R" || kind == "I" || kind == "S" || kind == "B") e.rs1 = 5'((u >> 15) & 31);
        if (kind == "R" || kind == "S" || kind == "B")                e.rs2 = 5'((u >> 20) & 31);
        if (w[6:0] == 7'h33)      e.alu_op = 4'(alt * 8 + f3);
        else if (w[6:0] == 7'h13) e.alu_op = (f3 == 5) ? 4'(alt * 8 + 5) : 4'(f3);
        else if (w[6:0] == 7'h63) e.alu_op = 4'd8;
        else                      e.alu_op = 4'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 13))
            0:  w[6:0] = 7'h33;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h0F;
            5:  w[6:0] = 7'h73;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h63;
            8:  w[6:0] = 7'h37;
            9:  w[6:0] = 7'h17;
            10: w[6:0] = 7'h6F;
            default: ;
        endcase
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam int SKID_V = (g == 0) ? 1 : 0;

        logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
        logic [31:0] in_inst, in_pc, out_pc, out_imm;
        logic [5:0]  out_fmt;
        logic [4:0]  out_rd, out_rs1, out_rs2;
        logic [2:0]  out_funct3;
        logic [3:0]  out_alu_op;
        exp_t        q[$];
        exp_t        pend;
        bit          fired;
        bit          done = 1'b0;
        string       tag = (SKID_V != 0) ? "skid1" : "skid0";

        decode_stage #(.WORD_SIZE(32), .XLEN(32), .SKID(SKID_V)) u_dut (
            .CLK(CLK), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
            .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_fmt(out_fmt),
            .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
            .out_imm(out_imm), .out_alu_op(out_alu_op), .out_illegal(out_illegal)
        );

        function automatic exp_t act_bundle();
            exp_t a;
            a.pc = out_pc; a.fmt = out_fmt; a.rd = out_rd; a.rs1 = out_rs1; a.rs2 = out_rs2;
            a.funct3 = out_funct3; a.imm = out_imm; a.alu_op = out_alu_op; a.illegal = out_illegal;
            return a;
        endfunction

        // Inputs change at the falling edge; everything is sampled 2 time units before the rising edge.
        task automatic settle();
            #3;
        endtask

        task automatic advance();
            fired = in_valid && in_ready && !flush && !rst;
            if (fired) q.push_back(pend);
            @(negedge CLK);
        endtask

        task automatic step();
            settle();
            advance();
        endtask

        task automatic present(input logic [31:0] inst, input exp_t e);
            in_valid = 1'b1;
            in_inst  = inst;
            in_pc    = e.pc;
            pend     = e;
        endtask

        task automatic send(input logic [31:0] inst, input exp_t e);
            present(inst, e);
            for (int n = 0; n < 20; n++) begin
                step();
                if (fired) break;
            end
            check({tag, "_accept_timeout"}, 128'(fired), 128'd1);
            in_valid = 1'b0;
        endtask

        task automatic chk_idle(input string name);
            check({tag, "_", name, "_outputs"},
                  128'({out_valid, out_pc, out_fmt, out_rd, out_rs1, out_rs2,
                        out_funct3, out_imm, out_alu_op, out_illegal}), 128'd0);
            check({tag, "_", name, "_in_ready"}, 128'(in_ready), 128'd1);
        endtask

        initial begin : monitor
            forever begin
                @(negedge CLK);
                #3;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL %s_unexpected_output: actual pc=%h inst bundle=%h required=none",
                                 tag, out_pc, act_bundle());
                    end else begin
                        check({tag, "_bundle"}, 128'(act_bundle()), 128'(q.pop_front()));
                    end
                end
                if (flush || rst) q.delete();
            end
        end

        initial begin : driver
            logic [31:0] w;
            logic [31:0] stream [8];
            logic [31:0] pc_ctr;
            int          n_acc;
            int          c;

            rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
            out_ready = 1'b1; pend = '0; pc_ctr = 32'h200;
            @(negedge CLK);
            step();
            step();
            rst = 1'b0;
            settle();
            chk_idle("reset");
            advance();

            // Directed encodings with hand-derived expectations.
            send(32'hFFB1_0093, mk(32'h100, 6'd2, 1, 2, 0, 0, 32'hFFFF_FFFB, 4'b0000, 1'b0));
            send(32'h4020_81B3, mk(32'h104, 6'd1, 3, 1, 2, 0, 32'h0,         4'b1000, 1'b0));
            send(32'h0053_2423, mk(32'h108, 6'd4, 0, 6, 5, 2, 32'h8,         4'b0000, 1'b0));
            send(32'h0000_0000, mk(32'h10C, 6'd0, 0, 0, 0, 0, 32'h0,         4'b0000, 1'b1));
            repeat (3) step();

            // Eight-instruction stream with a three-cycle downstream stall.
            for (int i = 0; i < 8; i++) stream[i] = rand_inst();
            n_acc = 0;
            c = 0;
            while (n_acc < 8 && c < 40) begin
                out_ready = !(c >= 3 && c <= 5);
                present(stream[n_acc], ref_model(stream[n_acc], pc_ctr));
                settle();
                if (c == 5) check({tag, "_stall_in_ready"}, 128'(in_ready), 128'd0);
                if (c == 7) check({tag, "_resume_in_ready"}, 128'(in_ready), 128'd1);
                if (c == 8) check({tag, "_full_rate_in_ready"}, 128'(in_ready), 128'd1);
                advance();
                if (fired) begin
                    n_acc++;
                    pc_ctr += 4;
                end
                c++;
            end
            check({tag, "_stream_count"}, 128'(n_acc), 128'd8);
            in_valid = 1'b0;
            out_ready = 1'b1;
            repeat (4) step();
            check({tag, "_stream_drained"}, 128'(q.size()), 128'd0);

            // Fill output (and skid) then flush with a new input presented.
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                w = rand_inst();
                present(w, ref_model(w, pc_ctr));
                settle();
                if (k == 2) check({tag, "_full_in_ready"}, 128'(in_ready), 128'd0);
                advance();
                if (fired) pc_ctr += 4;
            end
            flush = 1'b1;
            w = rand_inst();
            present(w, ref_model(w, pc_ctr));
            step();
            flush = 1'b0;
            in_valid = 1'b0;
            settle();
            check({tag, "_flush_out_valid"}, 128'(out_valid), 128'd0);
            check({tag, "_flush_in_ready"}, 128'(in_ready), 128'd1);
            advance();
            out_ready = 1'b1;
            repeat (3) step();

            // Randomised traffic with random backpressure and occasional flush.
            for (int k = 0; k < 400; k++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 9) < 7);
                flush     = ($urandom_range(0, 31) == 0);
                w = rand_inst();
                pend = ref_model(w, pc_ctr);
                in_inst = w;
                in_pc = pc_ctr;
                step();
                if (fired) pc_ctr += 4;
            end
            flush = 1'b0;
            in_valid = 1'b0;
            out_ready = 1'b1;
            repeat (4) step();
            check({tag, "_random_drained"}, 128'(q.size()), 128'd0);

            // Reset mid-stream, then reset and flush together.
            out_ready = 1'b0;
            repeat (2) begin
                w = rand_inst();
                present(w, ref_model(w, pc_ctr));
                step();
                if (fired) pc_ctr += 4;
            end
            rst = 1'b1;
            step();
            rst = 1'b0;
            in_valid = 1'b0;
            settle();
            chk_idle("rst_mid");
            advance();
            repeat (2) begin
                w = rand_inst();
                present(w, ref_model(w, pc_ctr));
                step();
                if (fired) pc_ctr += 4;
            end
            rst = 1'b1;
            flush = 1'b1;
            step();
            rst = 1'b0;
            flush = 1'b0;
            in_valid = 1'b0;
            settle();
            chk_idle("rst_flush");
            advance();
            out_ready = 1'b1;
            repeat (3) step();
            done = 1'b1;
        end
    end

    initial begin : main
        for (int t = 0; t < 30000; t++) begin
            if (g_ch[0].done && g_ch[1].done) break;
            @(posedge CLK);
        end
        check("channels_finished", 128'({g_ch[0].done, g_ch[1].done}), 128'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
